// File: rtl/tile_weight_counter_pkg.sv
// tile_weight_counter_pkg: shared state type, default widths and bound clamping for the weight-tile counter
package tile_weight_counter_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW_DEF = 16;
    localparam int AW_DEF = 20;

    function automatic logic [31:0] clamp_bound(input logic [31:0] b);
        return (b == 32'd0) ? 32'd1 : b;
    endfunction

endpackage

// File: rtl/tile_weight_counter_nest_stage.sv
// wcnt_nest_stage: one wrapping loop counter of the nest, chained to the next level through carry_out
module wcnt_nest_stage #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] cnt,
    output logic          at_max,
    output logic          carry_out
);

    assign at_max    = cnt == lim - CW'(1);
    assign carry_out = inc & at_max;

    // count up on inc, wrapping to zero after lim-1
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (inc) cnt <= at_max ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/tile_weight_counter.sv
// tile_weight_counter: three-level nested weight-tile read counter; define TILE_WEIGHT_COUNTER_PITCH_EN for padded-row addressing via row_pitch
module tile_weight_counter
    import tile_weight_counter_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clean,
    input  logic          ena,
    input  logic [CW-1:0] n0_lim,
    input  logic [CW-1:0] n1_lim,
    input  logic [CW-1:0] n2_lim,
    input  logic [AW-1:0] base_addr,
`ifdef TILE_WEIGHT_COUNTER_PITCH_EN
    input  logic [AW-1:0] row_pitch,
`endif
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [AW-1:0] addr,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nx;
    logic [CW-1:0] lim [3];
    logic [CW-1:0] cnt [3];
    logic [2:0]    inc, at_max, carry;
    logic          go, adv, last, clr;
    logic [AW-1:0] addr_step;

    assign go   = (state == IDLE) && start && !clean;
    assign adv  = (state == RUN) && ena && !clean;
    assign last = adv && (&at_max);
    assign clr  = go || clean;
    assign inc  = {carry[1], carry[0], adv};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_stage
            wcnt_nest_stage #(.CW(CW)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .clear    (clr),
                .inc      (inc[i]),
                .lim      (lim[i]),
                .cnt      (cnt[i]),
                .at_max   (at_max[i]),
                .carry_out(carry[i])
            );
        end
    endgenerate

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];

`ifdef TILE_WEIGHT_COUNTER_PITCH_EN
    logic [AW-1:0] pitch, row_start;

    assign addr_step = at_max[0] ? row_start + pitch : addr + AW'(1);

    // track the address of the current row's first element for padded rows
    always_ff @(posedge clk) begin
        if (rst) begin
            pitch     <= '0;
            row_start <= '0;
        end else if (go) begin
            pitch     <= row_pitch;
            row_start <= base_addr;
        end else if (adv && !last && at_max[0]) begin
            row_start <= row_start + pitch;
        end
    end
`else
    assign addr_step = addr + AW'(1);
`endif

    // next state: start launches a sweep, last element or abort returns to idle
    always_comb begin
        state_nx = (state == IDLE) ? (go ? RUN : IDLE) : ((clean || last) ? IDLE : RUN);
    end

    // state and handshake outputs; done comes from the outer-loop wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            valid <= state_nx == RUN;
            busy  <= state_nx == RUN;
            done  <= carry[2];
        end
    end

    // latch bounds at start and step the read address; the final element's address is held
    always_ff @(posedge clk) begin
        if (rst) begin
            lim[0] <= '0;
            lim[1] <= '0;
            lim[2] <= '0;
            addr   <= '0;
        end else if (go) begin
            lim[0] <= CW'(clamp_bound(32'(n0_lim)));
            lim[1] <= CW'(clamp_bound(32'(n1_lim)));
            lim[2] <= CW'(clamp_bound(32'(n2_lim)));
            addr   <= base_addr;
        end else if (adv && !last) begin
            addr <= addr_step;
        end
    end

endmodule

// File: tb/tb_tile_weight_counter.sv
// tb_tile_weight_counter: directed checks of the nested weight-tile counter (pitch test under TILE_WEIGHT_COUNTER_PITCH_EN)
module tb_tile_weight_counter;

    logic        clk = 1'b0;
    logic        rst, start, clean, ena;
    logic [15:0] n0_lim, n1_lim, n2_lim;
    logic [19:0] base_addr;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [19:0] addr;
    logic        valid, busy, done;
`ifdef TILE_WEIGHT_COUNTER_PITCH_EN
    logic [19:0] row_pitch = '0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [68:0] got, exp;

    always #5 clk = ~clk;

    tile_weight_counter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clean    (clean),
        .ena      (ena),
        .n0_lim   (n0_lim),
        .n1_lim   (n1_lim),
        .n2_lim   (n2_lim),
        .base_addr(base_addr),
`ifdef TILE_WEIGHT_COUNTER_PITCH_EN
        .row_pitch(row_pitch),
`endif
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .addr     (addr),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int l0, input int l1, input int l2, input int base);
        n0_lim = 16'(l0);
        n1_lim = 16'(l1);
        n2_lim = 16'(l2);
        base_addr = 20'(base);
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; clean = 1'b0; ena = 1'b0;
        n0_lim = '0; n1_lim = '0; n2_lim = '0; base_addr = '0;
        tick;
        tick;
        n_chk++;
        if ({valid, busy, done, cnt2, cnt1, cnt0, addr} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset: got %h expected 0", {valid, busy, done, cnt2, cnt1, cnt0, addr});
        end
        rst = 1'b0;
        ena = 1'b1;
        tick;
        n_chk++;
        if ({valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL ena_in_idle: got valid/busy %b expected 00", {valid, busy});
        end
        ena = 1'b0;
    endtask

    task automatic test_dense_sweep;
        launch(2, 3, 2, 'h100);
        ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            got = {valid, done, cnt2, cnt1, cnt0, addr[18:0]};
            exp = {1'b1, 1'b0, 16'(k / 6), 16'((k / 2) % 3), 16'(k % 2), 19'('h100 + k)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL dense_elem%0d: got %h expected %h (addr %h busy %b)", k, got, exp, addr, busy);
            end
            tick;
        end
        ena = 1'b0;
        n_chk++;
        if ({done, valid, busy, cnt2, cnt1, cnt0, addr} !== {3'b100, 48'd0, 20'h10B}) begin
            n_fail++;
            $display("FAIL dense_done: got done %b valid %b busy %b cnt %h/%h/%h addr %h expected 1 0 0 0/0/0 10b",
                     done, valid, busy, cnt2, cnt1, cnt0, addr);
        end
        tick;
        n_chk++;
        if ({done, valid, addr} !== {2'b00, 20'h10B}) begin
            n_fail++;
            $display("FAIL dense_done_pulse: got done %b valid %b addr %h expected 0 0 10b", done, valid, addr);
        end
    endtask

    task automatic test_stall;
        int e;
        e = 0;
        launch(2, 3, 2, 'h100);
        for (int c = 0; c < 23; c++) begin
            got = {valid, done, cnt2, cnt1, cnt0, addr[18:0]};
            exp = {1'b1, 1'b0, 16'(e / 6), 16'((e / 2) % 3), 16'(e % 2), 19'('h100 + e)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got %h expected %h", c, got, exp);
            end
            ena = (c % 2 == 0);
            tick;
            if (ena) e++;
        end
        ena = 1'b0;
        n_chk++;
        if ({done, valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL stall_done: got done/valid/busy %b expected 100", {done, valid, busy});
        end
        tick;
    endtask

    task automatic test_clean;
        int seen_done;
        seen_done = 0;
        launch(4, 4, 4, 'h40);
        ena = 1'b1;
        for (int k = 0; k < 10; k++) tick;
        n_chk++;
        if ({valid, cnt2, cnt1, cnt0, addr} !== {1'b1, 16'd0, 16'd2, 16'd2, 20'h4A}) begin
            n_fail++;
            $display("FAIL clean_pre: got valid %b cnt %h/%h/%h addr %h expected 1 0/2/2 4a", valid, cnt2, cnt1, cnt0, addr);
        end
        clean = 1'b1;
        start = 1'b1;
        tick;
        clean = 1'b0;
        start = 1'b0;
        ena = 1'b0;
        n_chk++;
        if ({valid, busy, done, cnt2, cnt1, cnt0} !== 51'd0) begin
            n_fail++;
            $display("FAIL clean_abort: got valid %b busy %b done %b cnt %h/%h/%h expected all 0",
                     valid, busy, done, cnt2, cnt1, cnt0);
        end
        for (int k = 0; k < 4; k++) begin
            if (done) seen_done++;
            tick;
        end
        n_chk++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL clean_no_done: got %0d done pulses expected 0", seen_done);
        end
        launch(1, 1, 1, 'h55);
        n_chk++;
        if ({valid, busy, done, cnt2, cnt1, cnt0, addr} !== {3'b110, 48'd0, 20'h55}) begin
            n_fail++;
            $display("FAIL single_elem: got valid %b busy %b done %b addr %h expected 1 1 0 55", valid, busy, done, addr);
        end
        ena = 1'b1;
        tick;
        ena = 1'b0;
        n_chk++;
        if ({done, valid, busy, addr} !== {3'b100, 20'h55}) begin
            n_fail++;
            $display("FAIL single_done: got done %b valid %b busy %b addr %h expected 1 0 0 55", done, valid, busy, addr);
        end
        tick;
    endtask

    task automatic test_zero_bound;
        launch(0, 2, 1, 'h200);
        ena = 1'b1;
        n_chk++;
        if ({valid, cnt2, cnt1, cnt0, addr} !== {1'b1, 48'd0, 20'h200}) begin
            n_fail++;
            $display("FAIL zero_elem0: got valid %b cnt %h/%h/%h addr %h expected 1 0/0/0 200", valid, cnt2, cnt1, cnt0, addr);
        end
        tick;
        n_chk++;
        if ({valid, done, cnt2, cnt1, cnt0, addr} !== {2'b10, 16'd0, 16'd1, 16'd0, 20'h201}) begin
            n_fail++;
            $display("FAIL zero_elem1: got valid %b done %b cnt %h/%h/%h addr %h expected 1 0 0/1/0 201",
                     valid, done, cnt2, cnt1, cnt0, addr);
        end
        tick;
        ena = 1'b0;
        n_chk++;
        if ({done, valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_done: got done/valid %b expected 10", {done, valid});
        end
        tick;
    endtask

    task automatic test_back_to_back;
        launch(2, 1, 1, 'h300);
        ena = 1'b1;
        n0_lim = 16'd3; n1_lim = 16'd3; n2_lim = 16'd3; base_addr = 20'h7;
        start = 1'b1;
        tick;
        n_chk++;
        if ({valid, done, cnt0, addr} !== {2'b10, 16'd1, 20'h301}) begin
            n_fail++;
            $display("FAIL b2b_midrun_start: got valid %b done %b cnt0 %h addr %h expected 1 0 1 301", valid, done, cnt0, addr);
        end
        n0_lim = 16'd1; n1_lim = 16'd2; n2_lim = 16'd1; base_addr = 20'h400;
        tick;
        n_chk++;
        if ({done, valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_done: got done/valid/busy %b expected 100", {done, valid, busy});
        end
        tick;
        start = 1'b0;
        n_chk++;
        if ({valid, done, cnt2, cnt1, cnt0, addr} !== {2'b10, 48'd0, 20'h400}) begin
            n_fail++;
            $display("FAIL b2b_elem0: got valid %b done %b cnt %h/%h/%h addr %h expected 1 0 0/0/0 400",
                     valid, done, cnt2, cnt1, cnt0, addr);
        end
        tick;
        n_chk++;
        if ({valid, cnt2, cnt1, cnt0, addr} !== {1'b1, 16'd0, 16'd1, 16'd0, 20'h401}) begin
            n_fail++;
            $display("FAIL b2b_elem1: got valid %b cnt %h/%h/%h addr %h expected 1 0/1/0 401", valid, cnt2, cnt1, cnt0, addr);
        end
        tick;
        ena = 1'b0;
        n_chk++;
        if ({done, valid, addr} !== {2'b10, 20'h401}) begin
            n_fail++;
            $display("FAIL b2b_done2: got done %b valid %b addr %h expected 1 0 401", done, valid, addr);
        end
        tick;
    endtask

`ifdef TILE_WEIGHT_COUNTER_PITCH_EN
    task automatic test_pitch;
        logic [19:0] exp_addr [6];
        exp_addr = '{20'd0, 20'd1, 20'd2, 20'd8, 20'd9, 20'd10};
        row_pitch = 20'd8;
        launch(3, 2, 1, 0);
        ena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if ({valid, addr} !== {1'b1, exp_addr[k]}) begin
                n_fail++;
                $display("FAIL pitch_elem%0d: got valid %b addr %h expected 1 %h", k, valid, addr, exp_addr[k]);
            end
            tick;
        end
        ena = 1'b0;
        n_chk++;
        if ({done, valid, addr} !== {2'b10, 20'd10}) begin
            n_fail++;
            $display("FAIL pitch_done: got done %b valid %b addr %h expected 1 0 a", done, valid, addr);
        end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_dense_sweep;
        test_stall;
        test_clean;
        test_zero_bound;
        test_back_to_back;
`ifdef TILE_WEIGHT_COUNTER_PITCH_EN
        test_pitch;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
